// File: rtl/reg_file_32x64.sv
// 1-bit 2:1 selector cell; used as the per-bit load/hold path of each register bank.
// Latency: combinational, 0 cycles.
// Backpressure: none; the output always follows its inputs.
module mux2_1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    // sel=0 recirculates a (held value), sel=1 passes b (new data)
    always_comb begin
        y = sel ? b : a;
    end

endmodule

// 1-bit 4:1 selector cell; final stage of the 32:1 read tree.
// Latency: combinational, 0 cycles.
// Backpressure: none; the output always follows its inputs.
module mux4_1 (
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic       y
);

    // select one of four group results
    always_comb begin
        y = d[sel];
    end

endmodule

// 1-bit 8:1 selector cell; first stage of the 32:1 read tree.
// Latency: combinational, 0 cycles.
// Backpressure: none; the output always follows its inputs.
module mux8_1 (
    input  logic [7:0] d,
    input  logic [2:0] sel,
    output logic       y
);

    // select one of eight register bits within a group
    always_comb begin
        y = d[sel];
    end

endmodule

// 1-bit 32:1 read selector: four mux8_1 on sel[2:0], then one mux4_1 on sel[4:3].
// Latency: combinational, 0 cycles.
// Backpressure: none; the output always follows its inputs.
module reg_read_mux32 (
    input  logic [31:0] d,
    input  logic [4:0]  sel,
    output logic        y
);

    logic [3:0] grp;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_grp
            mux8_1 u_mux8 (
                .d   (d[8*g +: 8]),
                .sel (sel[2:0]),
                .y   (grp[g])
            );
        end
    endgenerate

    mux4_1 u_mux4 (
        .d   (grp),
        .sel (sel[4:3]),
        .y   (y)
    );

endmodule

// 32x64 register file, two combinational read ports, one write port; X31 reads as zero.
// Latency: write visible after 1 rising edge; reads are combinational (0 cycles), no bypass.
// Backpressure: none; a write is accepted on every edge where RegWrite=1 and reset=0.
module reg_file_32x64 #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [4:0]        WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [4:0]        ReadRegister1,
    input  logic [4:0]        ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    // One load enable per real bank. Code 31 decodes to nothing, so a write
    // to X31 touches no state.
    logic [30:0] wr_en;

    // Flop outputs of every register, with X31 tied to constant zero so the
    // read tree sees a uniform 32-entry array.
    logic [31:0][DATA_W-1:0] reg_q;

    // 5:32 write-address decode gated by RegWrite
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < 31; i++) begin
            if (RegWrite && (WriteRegister == 5'(i))) begin
                wr_en[i] = 1'b1;
            end
        end
    end

    assign reg_q[31] = '0;

    genvar i, b;
    generate
        for (i = 0; i < 31; i++) begin : g_bank
            logic [DATA_W-1:0] bank_q;
            logic [DATA_W-1:0] bank_d;

            // Free-running clock on every bank: the mux2_1 either reloads the
            // current value or takes WriteData.
            for (b = 0; b < DATA_W; b++) begin : g_hold
                mux2_1 u_hold (
                    .a   (bank_q[b]),
                    .b   (WriteData[b]),
                    .sel (wr_en[i]),
                    .y   (bank_d[b])
                );
            end

            // bank storage; reset clears asynchronously and overrides any write
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    bank_q <= '0;
                end else begin
                    bank_q <= bank_d;
                end
            end

            assign reg_q[i] = bank_q;
        end

        // Bit-sliced read: bit b of each port picks bit b of one of 32 registers.
        for (b = 0; b < DATA_W; b++) begin : g_rd
            logic [31:0] col;

            for (i = 0; i < 32; i++) begin : g_col
                assign col[i] = reg_q[i][b];
            end

            reg_read_mux32 u_rd1 (
                .d   (col),
                .sel (ReadRegister1),
                .y   (ReadData1[b])
            );

            reg_read_mux32 u_rd2 (
                .d   (col),
                .sel (ReadRegister2),
                .y   (ReadData2[b])
            );
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_32x64.sv
// Directed, self-checking bench for reg_file_32x64.
// Inputs are driven on the falling edge; outputs are compared 1 ns later, before the next rising edge.
// Each table row's expected values are the pre-edge read results for that cycle.
module tb_reg_file_32x64;

    localparam int          DATA_W = 64;
    localparam logic [63:0] K      = 64'h0000_0100_0000_0001;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] BEEF   = 64'hDEAD_BEEF_0000_1234;
    localparam logic [63:0] A5     = 64'hA5A5_A5A5_A5A5_A5A5;

    logic              clk;
    logic              reset;
    logic              RegWrite;
    logic [4:0]        WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [4:0]        ReadRegister1;
    logic [4:0]        ReadRegister2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        rw;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [63:0] exp1;
        logic [63:0] exp2;
    } vec_t;

    vec_t vecs [9];

    reg_file_32x64 #(.DATA_W(DATA_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // rw, wa, wd, ra1, ra2, exp1 (pre-edge), exp2 (pre-edge)
        vecs[0] = '{1'b1, 5'd7,  BEEF,   5'd7,  5'd3,  64'h0000_0700_0000_0007, 64'h0000_0300_0000_0003};
        vecs[1] = '{1'b0, 5'd7,  64'h0,  5'd7,  5'd7,  BEEF,                    BEEF};
        vecs[2] = '{1'b1, 5'd3,  64'h1,  5'd7,  5'd3,  BEEF,                    64'h0000_0300_0000_0003};
        vecs[3] = '{1'b1, 5'd3,  64'h2,  5'd3,  5'd3,  64'h1,                   64'h1};
        vecs[4] = '{1'b0, 5'd3,  64'h0,  5'd3,  5'd3,  64'h2,                   64'h2};
        vecs[5] = '{1'b1, 5'd31, ONES,   5'd31, 5'd31, 64'h0,                   64'h0};
        vecs[6] = '{1'b0, 5'd31, 64'h0,  5'd31, 5'd31, 64'h0,                   64'h0};
        vecs[7] = '{1'b1, 5'd10, A5,     5'd10, 5'd7,  64'h0000_0A00_0000_000A, BEEF};
        vecs[8] = '{1'b0, 5'd10, 64'h0,  5'd10, 5'd30, A5,                      64'h0000_1E00_0000_001E};

        // Reset held for two edges with a write pending to X5
        reset         = 1'b1;
        RegWrite      = 1'b1;
        WriteRegister = 5'd5;
        WriteData     = ONES;
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_rd1", ReadData1, 64'h0);
        check("reset_hold_rd2", ReadData2, 64'h0);

        @(negedge clk);
        reset    = 1'b0;
        RegWrite = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = 5'(a);
            ReadRegister2 = 5'(31 - a);
            #1;
            check("post_reset_rd1", ReadData1, 64'h0);
            check("post_reset_rd2", ReadData2, 64'h0);
        end

        // Full sweep: register i <- i*K
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            RegWrite      = 1'b1;
            WriteRegister = 5'(i);
            WriteData     = 64'(i) * K;
        end
        @(negedge clk);
        RegWrite = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = 5'(a);
            ReadRegister2 = 5'(31 - a);
            #1;
            check("sweep_rd1", ReadData1, (a == 31) ? 64'h0 : 64'(a) * K);
            check("sweep_rd2", ReadData2, (a == 0)  ? 64'h0 : 64'(31 - a) * K);
        end

        // Table: write-enable low, same-register read/write, X31 writes, X10 setup
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            RegWrite      = vecs[v].rw;
            WriteRegister = vecs[v].wa;
            WriteData     = vecs[v].wd;
            ReadRegister1 = vecs[v].ra1;
            ReadRegister2 = vecs[v].ra2;
            #1;
            check($sformatf("vec%0d_rd1", v), ReadData1, vecs[v].exp1);
            check($sformatf("vec%0d_rd2", v), ReadData2, vecs[v].exp2);
        end

        // Async reset pulse between edges clears X10 without a clock edge
        @(posedge clk);
        #2;
        RegWrite      = 1'b0;
        ReadRegister1 = 5'd10;
        ReadRegister2 = 5'd7;
        #1;
        check("async_pre_rd1", ReadData1, A5);
        reset = 1'b1;
        #1;
        check("async_during_rd1", ReadData1, 64'h0);
        check("async_during_rd2", ReadData2, 64'h0);
        reset = 1'b0;
        #1;
        check("async_after_rd1", ReadData1, 64'h0);
        @(posedge clk);
        #1;
        check("async_edge_rd1", ReadData1, 64'h0);
        check("async_edge_rd2", ReadData2, 64'h0);

        // Walking one through X30 while X29 stays zero
        ReadRegister1 = 5'd30;
        ReadRegister2 = 5'd29;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            RegWrite      = 1'b1;
            WriteRegister = 5'd30;
            WriteData     = 64'h1 << k;
            @(posedge clk);
            #1;
            RegWrite = 1'b0;
            #1;
            check($sformatf("walk%0d_x30", k), ReadData1, 64'h1 << k);
            check($sformatf("walk%0d_x29", k), ReadData2, 64'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_file_32x64.md
# reg_file_32x64

Thirty-two-entry, 64-bit, two-read/one-write register file for the CPU datapath. It is the storage stage directly upstream of the mux tree. Each read port is a per-bit 32:1 selection built from the existing mux8_1 and mux4_1 cells: four mux8_1 plus one mux4_1 per bit. Register 31 is hardwired to zero. Outputs feed the ALU operand path and the store-data path.

## Interface
Parameters:
- DATA_W, 64, register and port data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears every register to 0 immediately, independent of clk.
- RegWrite  input  1  write enable for the write port.
- WriteRegister  input  5  write address.
- WriteData  input  DATA_W  write data.
- ReadRegister1  input  5  port 1 read address.
- ReadRegister2  input  5  port 2 read address.
- ReadData1  output  DATA_W  contents of ReadRegister1.
- ReadData2  output  DATA_W  contents of ReadRegister2.

## Operation
- Storage:
  - Registers X0..X30 are 31 banks of DATA_W D flip-flops.
  - X31 has no storage; it always reads 0.
- Write decode:
  - 5:32 decoder on WriteRegister, gated by RegWrite.
  - Bank i loads WriteData on a rising clk edge only when RegWrite=1 and WriteRegister=i.
  - Otherwise each bank recirculates its value through a per-bit mux2_1 hold path. No clock gating.
- Write to X31 when RegWrite=1: no state changes; X31 still reads 0.
- Read:
  - Purely combinational. ReadDataN equals register[ReadRegisterN].
  - Bit b of ReadDataN comes from a 32:1 tree over bit b of all 32 registers.
  - ReadRegisterN[2:0] drives the mux8_1 selects; ReadRegisterN[4:3] drives the final mux4_1.
- Both read ports are independent. Both may address the same register, including the one being written.
- No internal write-to-read bypass:
  - A read of the register being written returns the old value until the rising edge.
  - It returns the new value after the rising edge, once combinational settling completes.
- Reset:
  - While reset=1, all registers are held at 0 and writes are ignored.
  - Reset asserted mid-cycle clears state without waiting for clk.
  - Reads during reset return 0 for every address.
- Deassertion of reset must not coincide with a write edge. The first legal write is the first rising edge after reset falls.

## Timing
- Write latency: 1 clock. Data presented with RegWrite before edge k is readable after edge k.
- Read latency: 0 clocks (combinational from ReadRegisterN and register state).
  - Path: flop Q -> mux8_1 -> mux4_1 -> ReadDataN.
  - Must settle within one clock period at the CPU's nominal period.
- Output reset values: ReadData1 = ReadData2 = 0 for all addresses while reset=1 and after reset until the first write.
- Setup/hold: WriteRegister, WriteData and RegWrite must be stable around the rising edge. Addresses and data are not registered internally.
- Simultaneous events:
  - Read and write of the same register in one cycle: read shows the pre-edge value before the edge and the post-edge value after it.
  - Both ports reading X31 while X31 is written: both ports read 0.
- Out-of-range addresses are impossible (5-bit, 32 entries). All 32 codes are defined.

## Test plan
- Reset:
  - Stimulus: assert reset for 2 cycles with RegWrite=1, WriteRegister=5, WriteData=64'hFFFF_FFFF_FFFF_FFFF.
  - Response: after reset falls, reading every address 0..31 on both ports returns 0.
- Full sweep:
  - Stimulus: write i*64'h0000_0100_0000_0001 to register i for i=0..31, then read all addresses on both ports.
  - Response: X0..X30 return the written values; X31 returns 0.
- Write enable low:
  - Stimulus: write 64'hDEAD_BEEF_0000_1234 to X7, then one cycle with RegWrite=0, WriteRegister=7, WriteData=0.
  - Response: X7 still reads 64'hDEAD_BEEF_0000_1234.
- Same-register read/write:
  - Stimulus: X3=64'h1 established; set ReadRegister1=ReadRegister2=3, WriteRegister=3, WriteData=64'h2, RegWrite=1.
  - Response: both ports read 64'h1 before the edge and 64'h2 after it.
- Async reset mid-cycle:
  - Stimulus: X10=64'hA5A5_A5A5_A5A5_A5A5 established; pulse reset between clock edges.
  - Response: ReadData1 (ReadRegister1=10) goes to 0 during the pulse, before the next edge, and stays 0 after.
- Bit isolation:
  - Stimulus: walking-one pattern (1<<k, k=0..63) written to X30 with X29=0.
  - Response: X30 reads exactly 1<<k; X29 stays 0, showing no cross-bit or cross-register coupling in the mux tree.
